// File: rtl/elevator_request_scheduler.sv
// LOOK-policy scheduler between the button logic and the elevator controller: it collects
// floor calls, hands the controller one target at a time and times the door dwell after each stop.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = 16,
  parameter int FLOOR_W      = 4,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  complete,
  input  logic                  weight_alert,
  input  logic                  door_alert,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  direction,
  output logic                  door_cmd,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SELECT, WAIT, DWELL} state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_floor_q, target_floor_d;
  logic                  target_valid_q, target_valid_d;
  logic                  direction_q, direction_d;
  logic                  door_cmd_q, door_cmd_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      dwell_q, dwell_d;

  logic [NUM_FLOORS-1:0] call_mask, target_mask, set_mask, clear_mask;
  logic                  up_found, down_found, sel_found, sel_dir;
  logic [FLOOR_W-1:0]    up_floor, down_floor, sel_floor;
  logic                  alert, call_here, retarget;

  // Out-of-range call floors decode to an all-zero mask, so they never touch pending.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_decode
      assign call_mask[gi]   = call_valid && (call_floor == FLOOR_W'(gi));
      assign target_mask[gi] = (target_floor_q == FLOOR_W'(gi));
    end
  endgenerate

  // Nearest pending floor at or above / at or below the car.
  always_comb begin
    up_found   = 1'b0;
    up_floor   = '0;
    down_found = 1'b0;
    down_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (FLOOR_W'(i) >= current_floor)) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) <= current_floor)) begin
        down_found = 1'b1;
        down_floor = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    sel_found = up_found | down_found;
    sel_dir   = direction_q;
    sel_floor = '0;
    if (direction_q) begin
      sel_dir   = up_found;
      sel_floor = up_found ? up_floor : down_floor;
    end else begin
      sel_dir   = !down_found;
      sel_floor = down_found ? down_floor : up_floor;
    end
  end

  assign alert     = weight_alert | door_alert;
  assign call_here = (|call_mask) && (call_floor == current_floor);
  assign retarget  = (|call_mask) &&
                     (direction_q ? ((call_floor > current_floor) && (call_floor < target_floor_q))
                                  : ((call_floor < current_floor) && (call_floor > target_floor_q)));

  always_comb begin
    state_d        = state_q;
    target_floor_d = target_floor_q;
    target_valid_d = 1'b0;
    direction_d    = direction_q;
    door_cmd_d     = door_cmd_q;
    dwell_d        = dwell_q;
    clear_mask     = '0;
    // A call for the floor the doors are open at just extends the dwell.
    set_mask       = ((state_q == DWELL) && call_here) ? '0 : call_mask;
    if (!alert) begin
      unique case (state_q)
        IDLE: begin
          if (|pending_q) state_d = SELECT;
        end
        SELECT: begin
          if (sel_found) begin
            target_floor_d = sel_floor;
            direction_d    = sel_dir;
            target_valid_d = 1'b1;
            state_d        = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          if (complete && (current_floor == target_floor_q)) begin
            clear_mask = target_mask;
            dwell_d    = DWELL_LOAD;
            door_cmd_d = 1'b1;
            state_d    = DWELL;
          end else begin
            target_valid_d = 1'b1;
            if (retarget) target_floor_d = call_floor;
          end
        end
        DWELL: begin
          if (call_here) begin
            dwell_d = DWELL_LOAD;
          end else begin
            dwell_d = dwell_q - CNT_ONE;
            if (dwell_q == CNT_ONE) begin
              door_cmd_d = 1'b0;
              state_d    = (|pending_q) ? SELECT : IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Clear is applied after set so a call to the floor being served does not re-arm it.
    pending_d = (pending_q | set_mask) & ~clear_mask;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      target_floor_q <= '0;
      target_valid_q <= 1'b0;
      direction_q    <= 1'b1;
      door_cmd_q     <= 1'b0;
      busy_q         <= 1'b0;
      dwell_q        <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      target_floor_q <= target_floor_d;
      target_valid_q <= target_valid_d;
      direction_q    <= direction_d;
      door_cmd_q     <= door_cmd_d;
      busy_q         <= busy_d;
      dwell_q        <= dwell_d;
    end
  end

  assign target_floor = target_floor_q;
  assign target_valid = target_valid_q;
  assign direction    = direction_q;
  assign door_cmd     = door_cmd_q;
  assign pending      = pending_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios with fixed expectations, then a
// randomized run against a floor-walking behavioural model of the scheduling rules.
module tb_elevator_request_scheduler;
  localparam int NF = 16;
  localparam int DW = 8;

  logic       clock = 1'b0, reset = 1'b1, call_valid = 1'b0, complete = 1'b0;
  logic       weight_alert = 1'b0, door_alert = 1'b0;
  logic [3:0] call_floor = 4'd0, current_floor = 4'd0;
  logic [3:0] target_floor, tf12;
  logic       target_valid, direction, door_cmd, busy, tv12, dir12, door12, busy12;
  logic [15:0] pending;
  logic [11:0] pend12;
  int errors = 0, checks = 0;

  always #5 clock = ~clock;

  elevator_request_scheduler #(.NUM_FLOORS(16), .FLOOR_W(4), .DWELL_CYCLES(DW)) dut (
    .clock(clock), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .current_floor(current_floor), .complete(complete), .weight_alert(weight_alert),
    .door_alert(door_alert), .target_floor(target_floor), .target_valid(target_valid),
    .direction(direction), .door_cmd(door_cmd), .pending(pending), .busy(busy));

  elevator_request_scheduler #(.NUM_FLOORS(12), .FLOOR_W(4), .DWELL_CYCLES(DW)) dut12 (
    .clock(clock), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .current_floor(current_floor), .complete(complete), .weight_alert(weight_alert),
    .door_alert(door_alert), .target_floor(tf12), .target_valid(tv12),
    .direction(dir12), .door_cmd(door12), .pending(pend12), .busy(busy12));

  // Behavioural model: 0=idle 1=select 2=wait 3=dwell
  int      m_state, m_target, m_dwell;
  bit [15:0] m_pend;
  bit      m_tv, m_dir, m_door;

  function automatic int look(bit [15:0] p, int cur, bit up);
    int f;
    f = cur;
    while (f >= 0 && f < NF) begin
      if (p[f]) return f;
      f = up ? f + 1 : f - 1;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit [15:0] nxt;
    bit newc, here, between;
    int cf, cur, t;
    cf = int'(call_floor);
    cur = int'(current_floor);
    if (reset) begin
      m_state = 0; m_pend = 0; m_target = 0; m_tv = 0; m_dir = 1; m_door = 0; m_dwell = 0;
      return;
    end
    newc = call_valid && (cf < NF);
    here = newc && (cf == cur);
    between = newc && (m_dir ? (cf > cur && cf < m_target) : (cf < cur && cf > m_target));
    nxt = m_pend;
    if (newc && !(m_state == 3 && here)) nxt[cf] = 1'b1;
    m_tv = 0;
    if (!(weight_alert || door_alert)) begin
      case (m_state)
        0: if (m_pend != 0) m_state = 1;
        1: begin
          t = look(m_pend, cur, m_dir);
          if (t < 0) begin
            t = look(m_pend, cur, !m_dir);
            if (t >= 0) m_dir = !m_dir;
          end
          if (t >= 0) begin m_target = t; m_tv = 1; m_state = 2; end
          else m_state = 0;
        end
        2: begin
          if (complete && cur == m_target) begin
            nxt[m_target] = 1'b0; m_door = 1; m_dwell = DW; m_state = 3;
          end else begin
            m_tv = 1;
            if (between) m_target = cf;
          end
        end
        default: begin
          if (here) m_dwell = DW;
          else if (m_dwell == 1) begin
            m_dwell = 0; m_door = 0; m_state = (m_pend != 0) ? 1 : 0;
          end else m_dwell = m_dwell - 1;
        end
      endcase
    end
    m_pend = nxt;
  endtask

  always @(posedge clock) model_step();

  task automatic call(input logic [3:0] f);
    call_valid = 1'b1; call_floor = f;
    @(negedge clock);
    call_valid = 1'b0;
  endtask

  task automatic serve(input logic [3:0] f);
    current_floor = f; complete = 1'b1;
    @(negedge clock);
    complete = 1'b0;
  endtask

  task automatic wait_tv(output bit ok);
    int n;
    n = 0;
    while (target_valid !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    ok = (target_valid === 1'b1);
  endtask

  task automatic wait_door_low(output bit ok);
    int n;
    n = 0;
    while (door_cmd !== 1'b0 && n < 100) begin @(negedge clock); n++; end
    ok = (door_cmd === 1'b0);
  endtask

  task automatic count_door(output int cnt);
    cnt = 0;
    while (door_cmd === 1'b1 && cnt < 50) begin cnt++; @(negedge clock); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL reset_pending got=%h want=0000", pending); end
    checks++; if (target_floor !== 4'd0) begin errors++; $display("FAIL reset_target got=%0d want=0", target_floor); end
    checks++; if (target_valid !== 1'b0) begin errors++; $display("FAIL reset_tv got=%b want=0", target_valid); end
    checks++; if (direction !== 1'b1) begin errors++; $display("FAIL reset_dir got=%b want=1", direction); end
    checks++; if (door_cmd !== 1'b0) begin errors++; $display("FAIL reset_door got=%b want=0", door_cmd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int cnt;
    current_floor = 4'd0;
    call(4'd5);
    checks++; if (pending !== 16'h0020) begin errors++; $display("FAIL basic_pending got=%h want=0020", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
    @(negedge clock);
    checks++; if (busy !== 1'b1 || target_valid !== 1'b0) begin errors++; $display("FAIL basic_select got busy=%b tv=%b want busy=1 tv=0", busy, target_valid); end
    @(negedge clock);
    checks++; if (target_floor !== 4'd5 || target_valid !== 1'b1 || direction !== 1'b1) begin
      errors++; $display("FAIL basic_target got tf=%0d tv=%b dir=%b want tf=5 tv=1 dir=1", target_floor, target_valid, direction); end
    serve(4'd5);
    checks++; if (pending !== 16'h0 || door_cmd !== 1'b1 || target_valid !== 1'b0) begin
      errors++; $display("FAIL basic_complete got pend=%h door=%b tv=%b want pend=0000 door=1 tv=0", pending, door_cmd, target_valid); end
    count_door(cnt);
    checks++; if (cnt != DW) begin errors++; $display("FAIL basic_dwell got=%0d want=%0d", cnt, DW); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_end_busy got=%b want=0", busy); end
    $display("test_basic done");
  endtask

  task automatic test_look();
    bit ok;
    current_floor = 4'd3;
    call(4'd7);
    call(4'd1);
    wait_tv(ok);
    checks++; if (!ok || target_floor !== 4'd7 || direction !== 1'b1) begin
      errors++; $display("FAIL look_first got ok=%b tf=%0d dir=%b want tf=7 dir=1", ok, target_floor, direction); end
    serve(4'd7);
    wait_door_low(ok);
    wait_tv(ok);
    checks++; if (!ok || target_floor !== 4'd1 || direction !== 1'b0) begin
      errors++; $display("FAIL look_reverse got ok=%b tf=%0d dir=%b want tf=1 dir=0", ok, target_floor, direction); end
    serve(4'd1);
    wait_door_low(ok);
    checks++; if (!ok || pending !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL look_end got ok=%b pend=%h busy=%b want pend=0000 busy=0", ok, pending, busy); end
    $display("test_look done");
  endtask

  task automatic test_retarget();
    bit ok;
    current_floor = 4'd4;
    call(4'd9);
    wait_tv(ok);
    checks++; if (!ok || target_floor !== 4'd9 || direction !== 1'b1) begin
      errors++; $display("FAIL retarget_setup got ok=%b tf=%0d dir=%b want tf=9 dir=1", ok, target_floor, direction); end
    call(4'd6);
    checks++; if (target_floor !== 4'd6 || target_valid !== 1'b1 || pending !== 16'h0240) begin
      errors++; $display("FAIL retarget_swap got tf=%0d tv=%b pend=%h want tf=6 tv=1 pend=0240", target_floor, target_valid, pending); end
    serve(4'd6);
    checks++; if (pending !== 16'h0200) begin errors++; $display("FAIL retarget_clear got=%h want=0200", pending); end
    wait_door_low(ok);
    wait_tv(ok);
    checks++; if (!ok || target_floor !== 4'd9) begin errors++; $display("FAIL retarget_old got ok=%b tf=%0d want tf=9", ok, target_floor); end
    serve(4'd9);
    wait_door_low(ok);
    $display("test_retarget done");
  endtask

  task automatic test_alerts();
    bit ok;
    int cnt;
    call(4'd12);
    wait_tv(ok);
    checks++; if (!ok || target_floor !== 4'd12) begin errors++; $display("FAIL alert_setup got ok=%b tf=%0d want tf=12", ok, target_floor); end
    weight_alert = 1'b1; call_valid = 1'b1; call_floor = 4'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      call_valid = 1'b0;
      checks++; if (target_valid !== 1'b0 || target_floor !== 4'd12) begin
        errors++; $display("FAIL alert_hold[%0d] got tv=%b tf=%0d want tv=0 tf=12", k, target_valid, target_floor); end
    end
    weight_alert = 1'b0;
    @(negedge clock);
    checks++; if (target_valid !== 1'b1 || pending !== 16'h1004) begin
      errors++; $display("FAIL alert_resume got tv=%b pend=%h want tv=1 pend=1004", target_valid, pending); end
    serve(4'd12);
    door_alert = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++; if (door_cmd !== 1'b1) begin errors++; $display("FAIL alert_door[%0d] got=%b want=1", k, door_cmd); end
    end
    door_alert = 1'b0;
    count_door(cnt);
    checks++; if (cnt != DW) begin errors++; $display("FAIL alert_dwell_frozen got=%0d want=%0d", cnt, DW); end
    wait_tv(ok);
    checks++; if (!ok || target_floor !== 4'd2 || direction !== 1'b0) begin
      errors++; $display("FAIL alert_next got ok=%b tf=%0d dir=%b want tf=2 dir=0", ok, target_floor, direction); end
    serve(4'd2);
    wait_door_low(ok);
    $display("test_alerts done");
  endtask

  task automatic test_reload_and_same_cycle();
    bit ok;
    int cnt;
    call(4'd5);
    wait_tv(ok);
    serve(4'd5);
    repeat (DW - 2) @(negedge clock);
    call(4'd5);
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL reload_pending got=%h want=0000", pending); end
    count_door(cnt);
    checks++; if (cnt != DW) begin errors++; $display("FAIL reload_dwell got=%0d want=%0d", cnt, DW); end
    call(4'd12);
    wait_tv(ok);
    current_floor = 4'd12; complete = 1'b1; call_valid = 1'b1; call_floor = 4'd12;
    @(negedge clock);
    complete = 1'b0; call_valid = 1'b0;
    checks++; if (pending !== 16'h0 || door_cmd !== 1'b1) begin
      errors++; $display("FAIL same_floor_clear got pend=%h door=%b want pend=0000 door=1", pending, door_cmd); end
    wait_door_low(ok);
    call(4'd3);
    wait_tv(ok);
    current_floor = 4'd3; complete = 1'b1; call_valid = 1'b1; call_floor = 4'd8;
    @(negedge clock);
    complete = 1'b0; call_valid = 1'b0;
    checks++; if (pending !== 16'h0100) begin errors++; $display("FAIL other_floor_clear got=%h want=0100", pending); end
    wait_door_low(ok);
    wait_tv(ok);
    serve(4'd8);
    wait_door_low(ok);
    checks++; if (!ok || busy !== 1'b0 || pending !== 16'h0) begin
      errors++; $display("FAIL reload_end got ok=%b busy=%b pend=%h want busy=0 pend=0000", ok, busy, pending); end
    $display("test_reload_and_same_cycle done");
  endtask

  task automatic test_ignore();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    call(4'd15);
    checks++; if (pend12 !== 12'h0) begin errors++; $display("FAIL ignore_out_of_range got=%h want=000", pend12); end
    checks++; if (pending !== 16'h8000) begin errors++; $display("FAIL top_floor_call got=%h want=8000", pending); end
    call(4'd11);
    checks++; if (pend12 !== 12'h800) begin errors++; $display("FAIL small_top_call got=%h want=800", pend12); end
    $display("test_ignore done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    current_floor = 4'd0;
    call(4'd4);
    call(4'd10);
    wait_tv(ok);
    checks++; if (!ok || pending !== 16'h0410 || target_floor !== 4'd4) begin
      errors++; $display("FAIL resetmid_setup got ok=%b pend=%h tf=%0d want pend=0410 tf=4", ok, pending, target_floor); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if ({pending, target_floor, target_valid, direction, door_cmd, busy} !== {16'h0, 4'd0, 4'b0100}) begin
      errors++; $display("FAIL resetmid got pend=%h tf=%0d tv=%b dir=%b door=%b busy=%b want 0000 0 0 1 0 0",
                        pending, target_floor, target_valid, direction, door_cmd, busy); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int car, alert_left, rerr;
    logic [23:0] got, exp;
    reset = 1'b1; current_floor = 4'd0;
    @(negedge clock);
    reset = 1'b0;
    car = 0; alert_left = 0; rerr = 0;
    for (int n = 0; n < 3000 && rerr < 10; n++) begin
      call_valid = ($urandom_range(0, 7) == 0);
      call_floor = 4'($urandom_range(0, 15));
      if (alert_left > 0) alert_left--;
      else begin
        weight_alert = 1'b0; door_alert = 1'b0;
        if ($urandom_range(0, 39) == 0) begin
          alert_left = $urandom_range(1, 5);
          if ($urandom_range(0, 1) == 1) weight_alert = 1'b1; else door_alert = 1'b1;
        end
      end
      if (m_tv && car != m_target && $urandom_range(0, 1) == 1) car = (m_target > car) ? car + 1 : car - 1;
      current_floor = 4'(car);
      complete = (m_tv && car == m_target) || ($urandom_range(0, 24) == 0);
      @(negedge clock);
      got = {target_floor, target_valid, direction, door_cmd, busy, pending};
      exp = {4'(m_target), m_tv, m_dir, m_door, (m_state != 0), m_pend};
      checks++;
      if (got !== exp) begin
        errors++; rerr++;
        $display("FAIL random cycle=%0d got={tf,tv,dir,door,busy,pend}=%h want=%h", n, got, exp);
      end
    end
    call_valid = 1'b0; complete = 1'b0; weight_alert = 1'b0; door_alert = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_look();
    test_retarget();
    test_alerts();
    test_reload_and_same_cycle();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Collects floor calls from hall and car buttons into a pending-request bitmap.
- Chooses the next target floor with a LOOK policy: keep serving in the current direction, reverse only when nothing is left ahead.
- Presents the target to Elevator_Controller (target_floor to Request_Floor) and waits for its Complete.
- Holds a door dwell period, then selects the next target. Sits between the button-input logic and Elevator_Controller.

Parameters:
- NUM_FLOORS, 16, number of served floors (floors 0..NUM_FLOORS-1); max 16.
- FLOOR_W, 4, floor index width.
- DWELL_CYCLES, 8, clock cycles the door-open dwell lasts after a stop; must be 1 or more.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- call_valid  in  1  one-cycle strobe: new floor call
- call_floor  in  FLOOR_W  floor of the call; sampled when call_valid=1
- current_floor  in  FLOOR_W  controller Out_Current_Floor
- complete  in  1  controller Complete
- weight_alert  in  1  controller Weight_Alert
- door_alert  in  1  controller Door_Alert
- target_floor  out  FLOOR_W  floor requested from the controller
- target_valid  out  1  target_floor is valid and the car may move
- direction  out  1  scan direction; 1=up, 0=down
- door_cmd  out  1  door-open command; high during dwell
- pending  out  NUM_FLOORS  outstanding-call bitmap
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE, pending=0, target_floor=0, target_valid=0, direction=1, door_cmd=0, busy=0, dwell counter=0. Reset mid-operation discards all calls and returns to these values on the next edge.
- Call capture:
  - call_valid with call_floor<NUM_FLOORS sets pending[call_floor] at that edge.
  - call_floor>=NUM_FLOORS is ignored.
  - A duplicate call is a no-op.
- States: IDLE, SELECT, WAIT, DWELL.
- IDLE: when pending!=0, go to SELECT.
- SELECT (one cycle):
  - LOOK search from current_floor, current floor included, in the current direction. The first pending floor found becomes target_floor.
  - If none is found, invert direction and search again.
  - Then go to WAIT.
- WAIT:
  - target_valid=1 while both alerts are low.
  - On complete=1 with current_floor==target_floor: clear pending[target_floor], target_valid=0, load dwell counter = DWELL_CYCLES, go to DWELL.
  - complete with current_floor!=target_floor is ignored.
- Retarget in WAIT: a call strictly between current_floor and target_floor in the current direction replaces target_floor at the next edge. target_valid stays high. The old target stays pending.
- DWELL:
  - door_cmd=1; counter decrements each cycle.
  - At counter==1: if pending!=0 go to SELECT, else IDLE. The same edge deasserts door_cmd.
  - A call for current_floor during DWELL reloads the counter to DWELL_CYCLES and does not set the pending bit.
- Alerts:
  - While weight_alert|door_alert=1: target_valid forced 0, state frozen, dwell counter frozen, door_cmd held at its value.
  - Calls are still captured.
  - Operation resumes the cycle after both alerts are low.
- Simultaneous events:
  - A call to target_floor in the same cycle as its clear: clear wins, no re-set.
  - A call to a different floor in the same cycle as a clear: both take effect.
- Latency: call sampled at edge E; pending visible after E; SELECT after E+1; target_valid=1 after E+2 (idle, no alerts).
- Arithmetic: floor compares are unsigned FLOOR_W. The search never indexes outside 0..NUM_FLOORS-1, with no wrap-around at the top or bottom floor.
- Default parameters: direction at floor 15 with no calls above inverts to 0; direction at floor 0 with no calls below inverts to 1.

Test Plan:
- Reset, then call_floor=5 with current_floor=0 -> pending=0x0020; two edges later target_floor=5, target_valid=1, direction=1. Complete at floor 5 -> pending=0, door_cmd=1 for 8 cycles, then IDLE, busy=0.
- Current_floor=3, direction=1, calls 7 and 1 -> serves 7 first, then direction=0, target 1; pending ends 0.
- Target 9 in WAIT, current_floor=4, call 6 -> target_floor=6 next edge; after completing 6, target 9 is selected.
- Weight_alert pulsed 4 cycles during WAIT -> target_valid=0 for those 4 cycles, target_floor unchanged; call 2 captured meanwhile. door_alert during DWELL freezes the counter and door_cmd stays 1.
- Call for current floor 5 at dwell count 2 -> counter reloads to 8, pending[5] stays 0. Call 12 in the same cycle as completion at 12 -> pending[12]=0. call_floor=15 with NUM_FLOORS=12 -> ignored.
- Reset asserted in WAIT with pending=0x0410 -> next edge: all outputs at reset values, pending=0.
